// File: rtl/date_pkg.sv
// Shared definitions for the date sequencer: FSM state encoding, the base
// month-length table, BCD digit constants and small BCD helper functions.
package date_pkg;

  typedef enum logic {IDLE = 1'b0, CONV = 1'b1} state_t;

  localparam logic [3:0] BCD_ZERO = 4'd0;
  localparam logic [3:0] BCD_MAX  = 4'd9;

  // Index is the binary month; entries 0 and 13..15 are unreachable fillers.
  // February holds the common-year length; the leap adjustment lives in month_len.
  localparam logic [4:0] MONTH_DAYS [16] = '{
    5'd31, 5'd31, 5'd28, 5'd31, 5'd30, 5'd31, 5'd30, 5'd31,
    5'd31, 5'd30, 5'd31, 5'd30, 5'd31, 5'd31, 5'd31, 5'd31};

  // Year mod 4 == 0 straight from the BCD digits: an even tens digit needs
  // ones in {0,4,8}, an odd tens digit needs ones in {2,6}.
  function automatic logic bcd_leap(input logic [7:0] y);
    logic [3:0] ones;
    ones = y[3:0];
    if (y[4]) return (ones == 4'd2) || (ones == 4'd6);
    else      return (ones == 4'd0) || (ones == 4'd4) || (ones == 4'd8);
  endfunction

  // 3-digit BCD increment/decrement with per-digit carry; carry/borrow out
  // of the top digit is dropped, so 999+1=000 and 000-1=999.
  function automatic logic [11:0] bcd3_inc(input logic [11:0] v);
    logic [11:0] r;
    logic c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (c) begin
        if (r[i*4 +: 4] == BCD_MAX) r[i*4 +: 4] = BCD_ZERO;
        else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [11:0] bcd3_dec(input logic [11:0] v);
    logic [11:0] r;
    logic b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (b) begin
        if (r[i*4 +: 4] == BCD_ZERO) r[i*4 +: 4] = BCD_MAX;
        else begin
          r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // 2-digit variants wrap 99->00 and 00->99 for free.
  function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
    logic [11:0] t;
    t = bcd3_inc({4'h0, v});
    return t[7:0];
  endfunction

  function automatic logic [7:0] bcd2_dec(input logic [7:0] v);
    logic [11:0] t;
    t = bcd3_dec({4'h0, v});
    return t[7:0];
  endfunction

  // Double-dabble binary (0..511) to 3 BCD digits.
  function automatic logic [11:0] bin2bcd(input logic [8:0] b);
    logic [20:0] s;
    s = {12'd0, b};
    for (int i = 0; i < 9; i++) begin
      if (s[12:9]  >= 4'd5) s[12:9]  = s[12:9]  + 4'd3;
      if (s[16:13] >= 4'd5) s[16:13] = s[16:13] + 4'd3;
      if (s[20:17] >= 4'd5) s[20:17] = s[20:17] + 4'd3;
      s = s << 1;
    end
    return s[20:9];
  endfunction

  function automatic logic [7:0] bin2bcd2(input logic [8:0] b);
    logic [11:0] t;
    t = bin2bcd(b);
    return t[7:0];
  endfunction

endpackage

// File: rtl/month_len.sv
// Days in a month (28..31) for a binary month 1..12 and a leap flag.
// Ports: month (binary 1..12), leap (1 = February has 29 days), days (binary).
module month_len
  import date_pkg::*;
(
  input  logic [3:0] month,
  input  logic       leap,
  output logic [4:0] days
);
  assign days = (month == 4'd2 && leap) ? 5'd29 : MONTH_DAYS[month];
endmodule

// File: rtl/date_sequencer.sv
// Calendar date sequencer: BCD day-of-year, month, day-of-month and year,
// advanced up or down by a tick strobe, with a multi-cycle load that converts
// a binary day-of-year into month/day by walking the month table.
// Ports: clk, rst (async, active high); tick/down advance strobe and direction;
// leap_in external leap flag; load/load_doy load request; outputs doy_bcd,
// month, dom_bcd, year_bcd, leap_year, busy, year_wrap pulse, load_err pulse.
module date_sequencer
  import date_pkg::*;
#(
  parameter int         LEAP_MODE = 1,
  parameter logic [7:0] YEAR_INIT = 8'h00,
  parameter int         DOWN_EN   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        down,
  input  logic        leap_in,
  input  logic        load,
  input  logic [8:0]  load_doy,
  output logic [11:0] doy_bcd,
  output logic [3:0]  month,
  output logic [7:0]  dom_bcd,
  output logic [7:0]  year_bcd,
  output logic        leap_year,
  output logic        busy,
  output logic        year_wrap,
  output logic        load_err
);

  state_t      state, state_n;
  logic [11:0] doy_n;
  logic [3:0]  month_n, m, m_n, mon_prev;
  logic [7:0]  dom_n, year_n, year_prev;
  logic [8:0]  rem, rem_n, tgt, tgt_n, ylen_bin;
  logic        year_wrap_n, load_err_n, leap_prev, down_eff;
  logic [4:0]  cur_len, prev_len, trial_len;
  logic [11:0] ylen_bcd;

  assign year_prev = bcd2_dec(year_bcd);
  assign leap_year = (LEAP_MODE != 0) ? bcd_leap(year_bcd) : leap_in;
  // Leap status of the year a down-wrap lands in, so the new doy uses it.
  assign leap_prev = (LEAP_MODE != 0) ? bcd_leap(year_prev) : leap_in;
  assign ylen_bcd  = leap_year ? 12'h366 : 12'h365;
  assign ylen_bin  = leap_year ? 9'd366 : 9'd365;
  assign mon_prev  = (month == 4'd1) ? 4'd12 : month - 4'd1;
  assign down_eff  = (DOWN_EN != 0) && down;
  assign busy      = (state == CONV);

  month_len u_cur   (.month(month),    .leap(leap_year), .days(cur_len));
  month_len u_prev  (.month(mon_prev), .leap(leap_year), .days(prev_len));
  month_len u_trial (.month(m),        .leap(leap_year), .days(trial_len));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      doy_bcd   <= 12'h001;
      month     <= 4'd1;
      dom_bcd   <= 8'h01;
      year_bcd  <= YEAR_INIT;
      rem       <= '0;
      m         <= 4'd1;
      tgt       <= '0;
      year_wrap <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      doy_bcd   <= doy_n;
      month     <= month_n;
      dom_bcd   <= dom_n;
      year_bcd  <= year_n;
      rem       <= rem_n;
      m         <= m_n;
      tgt       <= tgt_n;
      year_wrap <= year_wrap_n;
      load_err  <= load_err_n;
    end
  end

  always_comb begin
    state_n     = state;
    doy_n       = doy_bcd;
    month_n     = month;
    dom_n       = dom_bcd;
    year_n      = year_bcd;
    rem_n       = rem;
    m_n         = m;
    tgt_n       = tgt;
    year_wrap_n = 1'b0;
    load_err_n  = 1'b0;
    case (state)
      IDLE: begin
        // Load has priority; a tick in the same cycle is dropped.
        if (load) begin
          if (load_doy != 9'd0 && load_doy <= ylen_bin) begin
            state_n = CONV;
            rem_n   = load_doy;
            m_n     = 4'd1;
            tgt_n   = load_doy;
          end else begin
            load_err_n = 1'b1;
          end
        end else if (tick) begin
          if (down_eff) begin
            if (doy_bcd == 12'h001) begin
              year_n      = year_prev;
              doy_n       = leap_prev ? 12'h366 : 12'h365;
              month_n     = 4'd12;
              dom_n       = 8'h31;
              year_wrap_n = 1'b1;
            end else begin
              doy_n = bcd3_dec(doy_bcd);
              if (dom_bcd == 8'h01) begin
                month_n = mon_prev;
                dom_n   = bin2bcd2({4'd0, prev_len});
              end else begin
                dom_n = bcd2_dec(dom_bcd);
              end
            end
          end else begin
            // >= rather than == so a doy of 366 left behind by an external
            // leap flag dropping still wraps on the next up tick.
            if (doy_bcd >= ylen_bcd) begin
              doy_n       = 12'h001;
              month_n     = 4'd1;
              dom_n       = 8'h01;
              year_n      = bcd2_inc(year_bcd);
              year_wrap_n = 1'b1;
            end else begin
              doy_n = bcd3_inc(doy_bcd);
              if (dom_bcd == bin2bcd2({4'd0, cur_len})) begin
                month_n = month + 4'd1;
                dom_n   = 8'h01;
              end else begin
                dom_n = bcd2_inc(dom_bcd);
              end
            end
          end
        end
      end
      CONV: begin
        // Outputs are only written on the exit cycle, all together.
        if (rem <= {4'd0, trial_len}) begin
          state_n = IDLE;
          month_n = m;
          dom_n   = bin2bcd2(rem);
          doy_n   = bin2bcd(tgt);
        end else begin
          rem_n = rem - {4'd0, trial_len};
          m_n   = m + 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_date_sequencer.sv
module tb_date_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick, down, leap_in, load;
  logic [8:0]  load_doy;
  logic [11:0] doy_bcd;
  logic [3:0]  month;
  logic [7:0]  dom_bcd, year_bcd;
  logic        leap_year, busy, year_wrap, load_err;

  // Second instance: external leap flag, down-count disabled.
  logic        tick2, down2, leap_in2, load2;
  logic [8:0]  load_doy2;
  logic [11:0] doy_bcd2;
  logic [3:0]  month2;
  logic [7:0]  dom_bcd2, year_bcd2;
  logic        leap_year2, busy2, year_wrap2, load_err2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  date_sequencer #(.LEAP_MODE(1), .YEAR_INIT(8'h23), .DOWN_EN(1)) dut (
    .clk(clk), .rst(rst), .tick(tick), .down(down), .leap_in(leap_in),
    .load(load), .load_doy(load_doy), .doy_bcd(doy_bcd), .month(month),
    .dom_bcd(dom_bcd), .year_bcd(year_bcd), .leap_year(leap_year),
    .busy(busy), .year_wrap(year_wrap), .load_err(load_err));

  date_sequencer #(.LEAP_MODE(0), .YEAR_INIT(8'h50), .DOWN_EN(0)) dut2 (
    .clk(clk), .rst(rst), .tick(tick2), .down(down2), .leap_in(leap_in2),
    .load(load2), .load_doy(load_doy2), .doy_bcd(doy_bcd2), .month(month2),
    .dom_bcd(dom_bcd2), .year_bcd(year_bcd2), .leap_year(leap_year2),
    .busy(busy2), .year_wrap(year_wrap2), .load_err(load_err2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Load request on dut; tick is held at with_tick for the load cycle and the
  // whole conversion. Returns busy cycle count and doy seen on the first busy cycle.
  task automatic do_load(input logic [8:0] v, input logic with_tick,
                         output int cyc, output logic [11:0] first_doy);
    load = 1'b1; load_doy = v; tick = with_tick;
    step(1);
    load = 1'b0;
    first_doy = doy_bcd;
    cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      step(1);
    end
    tick = 1'b0;
  endtask

  task automatic tick_once(input logic dir);
    tick = 1'b1; down = dir;
    step(1);
    tick = 1'b0; down = 1'b0;
  endtask

  task automatic chk_date(input string tag, input logic [11:0] d, input logic [3:0] mo,
                          input logic [7:0] dm, input logic [7:0] y);
    chk({tag, ".doy"},   doy_bcd, d);
    chk({tag, ".month"}, month, mo);
    chk({tag, ".dom"},   dom_bcd, dm);
    chk({tag, ".year"},  year_bcd, y);
  endtask

  initial begin
    int cyc;
    int y;
    logic [11:0] fd;
    rst = 1'b1; tick = 0; down = 0; leap_in = 0; load = 0; load_doy = '0;
    tick2 = 0; down2 = 0; leap_in2 = 1'b1; load2 = 0; load_doy2 = '0;
    #23;
    chk_date("reset", 12'h001, 4'd1, 8'h01, 8'h23);
    chk("reset.leap", leap_year, 1'b0);
    chk("reset.busy", busy, 1'b0);
    chk("reset.wrap", year_wrap, 1'b0);
    chk("reset.err", load_err, 1'b0);
    step(1);
    rst = 1'b0;
    step(1);

    // External-leap instance: leap flag follows leap_in.
    chk("ext.leap_hi", leap_year2, 1'b1);
    load2 = 1'b1; load_doy2 = 9'd366;
    step(1);
    load2 = 1'b0;
    cyc = 0;
    while (busy2 && cyc < 40) begin cyc++; step(1); end
    chk("ext.busy_cyc", cyc, 12);
    chk("ext.doy366", doy_bcd2, 12'h366);
    leap_in2 = 1'b0;
    step(2);
    chk("ext.leap_lo", leap_year2, 1'b0);
    chk("ext.hold_doy", doy_bcd2, 12'h366);
    chk("ext.hold_dom", dom_bcd2, 8'h31);
    // Down is ignored here, so this tick wraps forward.
    tick2 = 1'b1; down2 = 1'b1;
    step(1);
    tick2 = 1'b0;
    chk("ext.wrap_doy", doy_bcd2, 12'h001);
    chk("ext.wrap_year", year_bcd2, 8'h51);
    chk("ext.wrap_pulse", year_wrap2, 1'b1);
    tick2 = 1'b1;
    step(1);
    tick2 = 1'b0; down2 = 1'b0;
    chk("ext.no_down", doy_bcd2, 12'h002);
    chk("ext.wrap_gone", year_wrap2, 1'b0);

    // 31 up ticks from Jan 1.
    tick = 1'b1;
    step(31);
    tick = 1'b0;
    chk_date("up31", 12'h032, 4'd2, 8'h01, 8'h23);
    chk("up31.leap", leap_year, 1'b0);
    tick_once(1'b1);
    chk_date("down_feb1", 12'h031, 4'd1, 8'h31, 8'h23);
    tick_once(1'b0);
    chk_date("up_feb1", 12'h032, 4'd2, 8'h01, 8'h23);

    // Rejected loads in a common year.
    load = 1'b1; load_doy = 9'd366;
    step(1);
    load = 1'b0;
    chk("rej366.err", load_err, 1'b1);
    chk("rej366.busy", busy, 1'b0);
    step(1);
    chk("rej366.pulse", load_err, 1'b0);
    chk_date("rej366", 12'h032, 4'd2, 8'h01, 8'h23);
    load = 1'b1; load_doy = 9'd0; tick = 1'b1;
    step(1);
    load = 1'b0; tick = 1'b0;
    chk("rej0.err", load_err, 1'b1);
    chk_date("rej0", 12'h032, 4'd2, 8'h01, 8'h23);

    // Dec 31 of 2023, then roll into a leap year.
    do_load(9'd365, 1'b0, cyc, fd);
    chk("l365.busy_cyc", cyc, 12);
    chk_date("l365", 12'h365, 4'd12, 8'h31, 8'h23);
    tick_once(1'b0);
    chk_date("wrap24", 12'h001, 4'd1, 8'h01, 8'h24);
    chk("wrap24.leap", leap_year, 1'b1);
    chk("wrap24.pulse", year_wrap, 1'b1);
    step(1);
    chk("wrap24.pulse_end", year_wrap, 1'b0);

    do_load(9'd366, 1'b0, cyc, fd);
    chk("l366.busy_cyc", cyc, 12);
    chk("l366.hold", fd, 12'h001);
    chk_date("l366", 12'h366, 4'd12, 8'h31, 8'h24);
    tick_once(1'b1);
    chk_date("dn366", 12'h365, 4'd12, 8'h30, 8'h24);

    // Feb 29 via load with a simultaneous tick and ticks during conversion;
    // February exits on the second conversion cycle (m=2).
    do_load(9'd60, 1'b1, cyc, fd);
    chk("l60.busy_cyc", cyc, 2);
    chk_date("l60", 12'h060, 4'd2, 8'h29, 8'h24);
    tick_once(1'b0);
    chk_date("mar1", 12'h061, 4'd3, 8'h01, 8'h24);
    tick_once(1'b1);
    chk_date("feb29", 12'h060, 4'd2, 8'h29, 8'h24);

    // Walk forward to 2099 using load-to-last-day plus one tick per year.
    y = 24;
    while (y != 99) begin
      do_load((y % 4 == 0) ? 9'd366 : 9'd365, 1'b0, cyc, fd);
      tick_once(1'b0);
      y++;
    end
    chk_date("y99", 12'h001, 4'd1, 8'h01, 8'h99);
    chk("y99.leap", leap_year, 1'b0);
    do_load(9'd365, 1'b0, cyc, fd);
    tick_once(1'b0);
    chk_date("wrap00", 12'h001, 4'd1, 8'h01, 8'h00);
    chk("wrap00.leap", leap_year, 1'b1);
    chk("wrap00.pulse", year_wrap, 1'b1);
    step(1);
    chk("wrap00.pulse_end", year_wrap, 1'b0);
    tick_once(1'b1);
    chk_date("dnwrap99", 12'h365, 4'd12, 8'h31, 8'h99);
    chk("dnwrap99.pulse", year_wrap, 1'b1);

    // Reset in the middle of a conversion.
    load = 1'b1; load_doy = 9'd300;
    step(1);
    load = 1'b0;
    step(2);
    chk("midconv.busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk_date("midrst", 12'h001, 4'd1, 8'h01, 8'h23);
    chk("midrst.busy", busy, 1'b0);
    step(1);
    rst = 1'b0;
    step(15);
    chk_date("postrst", 12'h001, 4'd1, 8'h01, 8'h23);
    chk("postrst.busy", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
